// File: rtl/hazard_detection_unit_pkg.sv
// Shared RISC-V opcode definitions and source-usage classification,
// used by control_path and the hazard detection unit.
package riscv_defs;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_NOP    = 7'b0000000;

  typedef struct packed {
    logic use_rs1;
    logic use_rs2;
    logic is_branch;
  } op_class_t;

  function automatic op_class_t classify(input logic [6:0] opcode);
    op_class_t c;
    c.use_rs2   = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    c.use_rs1   = c.use_rs2 || (opcode == OPC_LOAD) || (opcode == OPC_OP_IMM);
    c.is_branch = (opcode == OPC_BRANCH);
    return c;
  endfunction

endpackage

// File: rtl/hazard_detection_unit_compare.sv
// Producer/consumer register match: producer rd is non-zero and equals a
// source register the consumer actually reads. Purely combinational.
module hazard_compare (
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use_rs1,
  input  logic       use_rs2,
  output logic       match
);

  assign match = (rd != 5'd0) &&
                 ((use_rs1 && (rd == rs1)) || (use_rs2 && (rd == rs2)));

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use / branch-operand stall and early-branch flush control.
// Optional perf counters (stall_cycles, flush_count) enabled by HAZARD_PERF_EN.
module hazard_detection_unit
  import riscv_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  id_opcode,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_MemRead,
  input  logic        ex_RegWrite,
  input  logic [4:0]  mem_rd,
  input  logic        mem_MemRead,
  input  logic        id_branch_taken,
  output logic        PCWrite,
  output logic        IF_IDWrite,
  output logic        control_sel,
  output logic        IF_ID_flush,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  op_class_t  cls;
  logic       ex_match;
  logic       mem_match;
  logic       haz_1;
  logic       haz_2;
  logic       stall;
  logic [1:0] cnt;
  logic [1:0] cnt_nxt;

  assign cls = classify(id_opcode);

  hazard_compare u_cmp_ex (
    .rd      (ex_rd),
    .rs1     (id_rs1),
    .rs2     (id_rs2),
    .use_rs1 (cls.use_rs1),
    .use_rs2 (cls.use_rs2),
    .match   (ex_match)
  );

  hazard_compare u_cmp_mem (
    .rd      (mem_rd),
    .rs1     (id_rs1),
    .rs2     (id_rs2),
    .use_rs1 (cls.use_rs1),
    .use_rs2 (cls.use_rs2),
    .match   (mem_match)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= 2'd0;
    else       cnt <= cnt_nxt;
  end

  always_comb begin
    haz_1       = 1'b0;
    haz_2       = 1'b0;
    stall       = 1'b0;
    cnt_nxt     = cnt;
    haz_2 = ex_MemRead && ex_match && cls.is_branch;
    haz_1 = (ex_MemRead  && ex_match  && !cls.is_branch) ||
            (ex_RegWrite && ex_match  &&  cls.is_branch) ||
            (mem_MemRead && mem_match &&  cls.is_branch);
    if (cnt == 2'd0) begin
      // Stall starts in the detection cycle; cnt holds the remaining extra cycles.
      stall   = haz_1 || haz_2;
      cnt_nxt = haz_2 ? 2'd1 : 2'd0;
    end else begin
      stall   = 1'b1;
      cnt_nxt = cnt - 2'd1;
    end
    PCWrite     = !stall;
    IF_IDWrite  = !stall;
    control_sel = stall;
    IF_ID_flush = !stall && id_branch_taken && cls.is_branch;
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      if (stall && (stall_q != 16'hFFFF))       stall_q <= stall_q + 16'd1;
      if (IF_ID_flush && (flush_q != 16'hFFFF)) flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = 16'd0;
  assign flush_count  = 16'd0;
`endif

endmodule
